spi_xfer_ctrl: RTL and testbench

Transaction sequencer that sits directly above the byte-level SPI master core. It accepts a multi-byte transfer request and owns the active-low slave-select lines for up to N_SS slaves. It feeds TX bytes to the core one at a time, returns each RX byte, and enforces select setup/hold timing around the burst.

---
 rtl/spi_ctrl_pkg.sv | 24 ++
 rtl/spi_xfer_ctrl_if.sv | 31 +++
 rtl/spi_ctrl_tmr.sv | 27 ++
 rtl/spi_xfer_ctrl.sv | 164 ++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and default timing for the SPI transfer sequencer.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_XFER,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam int unsigned SETUP_CYC_DEF   = 8;
  localparam int unsigned HOLD_CYC_DEF    = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 65535;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Host-side request / TX / RX / status bundle of the SPI transfer sequencer.
interface spi_xfer_ctrl_if #(
  parameter int unsigned N_SS  = 4,
  parameter int unsigned LEN_W = 5
);
  localparam int unsigned SS_W = $clog2(N_SS);

  logic             req_valid;
  logic             req_ready;
  logic [SS_W-1:0]  req_ss;
  logic [LEN_W-1:0] req_len;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             xfer_done;
  logic             err;
  logic             busy;

  modport master (
    output req_valid, req_ss, req_len, tx_data, tx_valid,
    input  req_ready, tx_ready, rx_data, rx_valid, xfer_done, err, busy
  );

  modport slave (
    input  req_valid, req_ss, req_len, tx_data, tx_valid,
    output req_ready, tx_ready, rx_data, rx_valid, xfer_done, err, busy
  );

endinterface

// File: rtl/spi_ctrl_tmr.sv
// Loadable down-counter used for select setup, select hold and byte timeout.
module spi_ctrl_tmr #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Multi-byte SPI transfer sequencer above the byte-level master core.
// Define SPI_XFER_CTRL_TIMEOUT_EN to abort a byte that never completes.
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned N_SS        = 4,
  parameter int unsigned LEN_W       = 5,
  parameter int unsigned SETUP_CYC   = SETUP_CYC_DEF,
  parameter int unsigned HOLD_CYC    = HOLD_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  spi_xfer_ctrl_if.slave    host,
  output logic [N_SS-1:0]   ss_n,
  output logic [7:0]        spi_din,
  output logic              spi_start,
  input  logic              spi_ready,
  input  logic              spi_done_tick,
  input  logic [7:0]        spi_dout
);

  localparam int unsigned SS_W  = $clog2(N_SS);
  localparam int unsigned TMR_W = $clog2(max3(SETUP_CYC, HOLD_CYC, TIMEOUT_CYC) + 1);

  state_t           state, next_state;
  logic [SS_W-1:0]  sel, next_sel;
  logic [LEN_W-1:0] rem, next_rem;
  logic [N_SS-1:0]  ss_n_nxt;
  logic             tx_pop_c;
  logic             rx_c;
  logic             done_c;
  logic             tmr_load, tmr_en, tmr_zero;
  logic [TMR_W-1:0] tmr_val;
  logic             req_ready_q, busy_q, rx_valid_q, xfer_done_q;
  logic [7:0]       rx_data_q;
`ifdef SPI_XFER_CTRL_TIMEOUT_EN
  logic             err_c;
  logic             err_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    next_sel   = sel;
    next_rem   = rem;
    tx_pop_c   = 1'b0;
    rx_c       = 1'b0;
    done_c     = 1'b0;
`ifdef SPI_XFER_CTRL_TIMEOUT_EN
    err_c      = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (host.req_valid) begin
          next_sel   = host.req_ss;
          next_rem   = host.req_len;
          next_state = (host.req_len == '0) ? ST_DONE : ST_SETUP;
        end
      end
      ST_SETUP: if (tmr_zero) next_state = ST_LOAD;
      ST_LOAD: begin
        if (host.tx_valid && spi_ready) begin
          tx_pop_c   = 1'b1;
          next_state = ST_XFER;
        end
      end
      ST_XFER: begin
        if (spi_done_tick) begin
          rx_c       = 1'b1;
          next_rem   = rem - LEN_W'(1);
          next_state = (next_rem == '0) ? ST_HOLD : ST_LOAD;
        end
`ifdef SPI_XFER_CTRL_TIMEOUT_EN
        else if (tmr_zero) begin
          // Stuck byte: drop the rest of the burst and release the slave.
          done_c     = 1'b1;
          err_c      = 1'b1;
          next_state = ST_IDLE;
        end
`endif
      end
      ST_HOLD: if (tmr_zero) next_state = ST_DONE;
      ST_DONE: begin
        done_c     = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase

    ss_n_nxt = '1;
    if (next_state inside {ST_SETUP, ST_LOAD, ST_XFER, ST_HOLD}) ss_n_nxt[next_sel] = 1'b0;

    // Timer reloads on every state change with the length of the state being entered.
    tmr_load = (next_state != state);
    case (next_state)
      ST_SETUP: tmr_val = TMR_W'(SETUP_CYC - 1);
      ST_HOLD:  tmr_val = TMR_W'(HOLD_CYC - 1);
      ST_XFER:  tmr_val = TMR_W'(TIMEOUT_CYC - 1);
      default:  tmr_val = '0;
    endcase
`ifdef SPI_XFER_CTRL_TIMEOUT_EN
    tmr_en = (state == ST_SETUP) || (state == ST_HOLD) || (state == ST_XFER);
`else
    tmr_en = (state == ST_SETUP) || (state == ST_HOLD);
`endif
  end

  spi_ctrl_tmr #(.W(TMR_W)) u_tmr (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero_c   (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel         <= '0;
      rem         <= '0;
      ss_n        <= '1;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      xfer_done_q <= 1'b0;
    end else begin
      sel         <= next_sel;
      rem         <= next_rem;
      ss_n        <= ss_n_nxt;
      req_ready_q <= (next_state == ST_IDLE);
      busy_q      <= (next_state != ST_IDLE);
      rx_valid_q  <= rx_c;
      xfer_done_q <= done_c;
      if (rx_c) rx_data_q <= spi_dout;
    end
  end

`ifdef SPI_XFER_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_c;
  end
  assign host.err = err_q;
`else
  assign host.err = 1'b0;
`endif

  // Byte launch is combinational so the core starts in the same cycle tx_data is popped.
  assign spi_start      = tx_pop_c;
  assign spi_din        = tx_pop_c ? host.tx_data : 8'h00;
  assign host.tx_ready  = tx_pop_c;
  assign host.req_ready = req_ready_q;
  assign host.busy      = busy_q;
  assign host.rx_valid  = rx_valid_q;
  assign host.rx_data   = rx_data_q;
  assign host.xfer_done = xfer_done_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a simple echoing byte-core model.
module tb_spi_xfer_ctrl;

`ifdef SPI_XFER_CTRL_TIMEOUT_EN
  localparam int unsigned TO_CYC = 20;
`else
  localparam int unsigned TO_CYC = 65535;
`endif
  localparam int CORE_LAT = 3;

  logic       clk;
  logic       reset;
  logic [3:0] ss_n;
  logic [7:0] spi_din;
  logic       spi_start;
  logic       spi_ready;
  logic       spi_done_tick;
  logic [7:0] spi_dout;

  spi_xfer_ctrl_if #(.N_SS(4), .LEN_W(5)) host_if ();

  spi_xfer_ctrl #(
    .N_SS(4), .LEN_W(5), .SETUP_CYC(8), .HOLD_CYC(8), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .host          (host_if),
    .ss_n          (ss_n),
    .spi_din       (spi_din),
    .spi_start     (spi_start),
    .spi_ready     (spi_ready),
    .spi_done_tick (spi_done_tick),
    .spi_dout      (spi_dout)
  );

  always #5 clk = ~clk;

  int n_assert, n_fail;
  int cyc, n_start, n_txr, n_rx, n_done, n_err, n_fall, n_rise, n_hs, bad_start, din_bad;
  int start_cyc, tick_cyc, rx_cyc, done_cyc, err_cyc, d1;
  int fall_cyc[8], rise_cyc[8], hs_cyc[8];
  logic [3:0] fall_val[8];
  logic [3:0] prev_ss;
  logic [7:0] last_rx;
  int core_cnt;
  bit start_pending, core_mute, echo_inv, tx_toggle, tx_pop;
  logic [7:0] core_din, echo_val, tx_base;
  int tx_idx, tx_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_start = 0; n_txr = 0; n_rx = 0; n_done = 0; n_err = 0;
    n_fall = 0; n_rise = 0; n_hs = 0; bad_start = 0; din_bad = 0;
    start_cyc = 0; tick_cyc = 0; rx_cyc = 0; done_cyc = 0; err_cyc = 0;
    prev_ss = 4'hF; last_rx = 8'h00;
    for (int i = 0; i < 8; i++) begin
      fall_cyc[i] = 0; rise_cyc[i] = 0; hs_cyc[i] = 0; fall_val[i] = 4'hF;
    end
  endtask

  // One clock: observe at the falling edge, then update core and TX source after the rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    tx_pop = 0;
    if (spi_start) begin
      n_start++; start_cyc = cyc; start_pending = 1; core_din = spi_din;
      if (!(host_if.tx_valid && spi_ready && host_if.tx_ready)) bad_start++;
      if (spi_din !== tx_base + 8'(tx_idx)) din_bad++;
    end
    if (host_if.tx_ready) begin n_txr++; tx_pop = 1; end
    if (spi_done_tick) tick_cyc = cyc;
    if (host_if.rx_valid) begin n_rx++; last_rx = host_if.rx_data; rx_cyc = cyc; end
    if (host_if.xfer_done) begin n_done++; done_cyc = cyc; end
    if (host_if.err) begin n_err++; err_cyc = cyc; end
    if (host_if.req_valid && host_if.req_ready && n_hs < 8) begin hs_cyc[n_hs] = cyc; n_hs++; end
    if (ss_n != 4'hF && prev_ss == 4'hF && n_fall < 8) begin
      fall_cyc[n_fall] = cyc; fall_val[n_fall] = ss_n; n_fall++;
    end
    if (ss_n == 4'hF && prev_ss != 4'hF && n_rise < 8) begin rise_cyc[n_rise] = cyc; n_rise++; end
    prev_ss = ss_n;
    @(posedge clk); #1;
    spi_done_tick = 0;
    if (start_pending) begin
      start_pending = 0; core_cnt = CORE_LAT; spi_ready = 0;
    end else if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0 && !core_mute) begin
        spi_done_tick = 1; spi_dout = echo_inv ? ~core_din : echo_val; spi_ready = 1;
      end
    end
    if (tx_pop) tx_idx++;
    host_if.tx_data  = tx_base + 8'(tx_idx);
    host_if.tx_valid = (tx_idx < tx_total) && (!tx_toggle || cyc[0]);
  endtask

  task automatic send_req(input logic [1:0] ss, input logic [4:0] len, input bit hold_valid);
    int hs0 = n_hs;
    int i = 0;
    host_if.req_ss = ss; host_if.req_len = len; host_if.req_valid = 1;
    while (n_hs == hs0 && i < 50) begin step(); i++; end
    chk("req_accept", 32'(n_hs > hs0), 1);
    if (!hold_valid) host_if.req_valid = 0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int i = 0;
    while (n_done < target && i < budget) begin step(); i++; end
    chk(tag, 32'(n_done >= target), 1);
  endtask

  task automatic setup_tx(input int total, input logic [7:0] base, input bit toggle);
    tx_idx = 0; tx_total = total; tx_base = base; tx_toggle = toggle;
  endtask

  initial begin
    clk = 0; reset = 1; cyc = 0; n_assert = 0; n_fail = 0;
    spi_ready = 1; spi_done_tick = 0; spi_dout = 8'h00;
    core_cnt = 0; start_pending = 0; core_mute = 0; echo_inv = 0; echo_val = 8'h00; core_din = 8'h00;
    host_if.req_valid = 0; host_if.req_ss = '0; host_if.req_len = '0;
    host_if.tx_data = 8'h00; host_if.tx_valid = 0;
    setup_tx(0, 8'h00, 0); tx_pop = 0;
    clear_stats();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ss_n", 32'(ss_n), 32'hF);
    chk("rst_req_ready", 32'(host_if.req_ready), 1);
    chk("rst_busy", 32'(host_if.busy), 0);
    chk("rst_tx_ready", 32'(host_if.tx_ready), 0);
    chk("rst_rx_valid", 32'(host_if.rx_valid), 0);
    chk("rst_xfer_done", 32'(host_if.xfer_done), 0);
    chk("rst_err", 32'(host_if.err), 0);
    chk("rst_spi_start", 32'(spi_start), 0);
    chk("rst_rx_data", 32'(host_if.rx_data), 0);
    chk("rst_spi_din", 32'(spi_din), 0);
    @(posedge clk); #1 reset = 0;
    step(); step();

    // Single byte to slave 2
    clear_stats(); setup_tx(1, 8'hA5, 0); echo_inv = 0; echo_val = 8'h3C;
    send_req(2'd2, 5'd1, 0);
    wait_done(1, 100, "t1_finish");
    repeat (3) step();
    chk("t1_ss_val", 32'(fall_val[0]), 32'hB);
    chk("t1_ss_fall", 32'(fall_cyc[0] - hs_cyc[0]), 1);
    chk("t1_setup", 32'(start_cyc - fall_cyc[0]), 8);
    chk("t1_nstart", 32'(n_start), 1);
    chk("t1_din", 32'(core_din), 32'hA5);
    chk("t1_nrx", 32'(n_rx), 1);
    chk("t1_rx_data", 32'(last_rx), 32'h3C);
    chk("t1_rx_lat", 32'(rx_cyc - tick_cyc), 1);
    chk("t1_hold", 32'(rise_cyc[0] - tick_cyc), 9);
    chk("t1_ndone", 32'(n_done), 1);
    chk("t1_done_pos", 32'(done_cyc - rise_cyc[0]), 1);
    chk("t1_err", 32'(n_err), 0);

    // Four-byte burst with tx_valid toggling
    clear_stats(); setup_tx(4, 8'h01, 1); echo_inv = 1;
    send_req(2'd1, 5'd4, 0);
    wait_done(1, 300, "t2_finish");
    repeat (3) step();
    chk("t2_nstart", 32'(n_start), 4);
    chk("t2_ntx_ready", 32'(n_txr), 4);
    chk("t2_bad_start", 32'(bad_start), 0);
    chk("t2_din_bad", 32'(din_bad), 0);
    chk("t2_nfall", 32'(n_fall), 1);
    chk("t2_nrise", 32'(n_rise), 1);
    chk("t2_ss_val", 32'(fall_val[0]), 32'hD);
    chk("t2_nrx", 32'(n_rx), 4);
    chk("t2_last_rx", 32'(last_rx), 32'hFB);
    chk("t2_ndone", 32'(n_done), 1);

    // Zero length
    clear_stats(); setup_tx(0, 8'h00, 0);
    send_req(2'd3, 5'd0, 0);
    wait_done(1, 20, "t3_finish");
    repeat (3) step();
    chk("t3_done_lat", 32'(done_cyc - hs_cyc[0]), 2);
    chk("t3_nfall", 32'(n_fall), 0);
    chk("t3_nstart", 32'(n_start), 0);
    chk("t3_ndone", 32'(n_done), 1);

    // Back-to-back: second request held valid during the first
    clear_stats(); setup_tx(2, 8'h10, 0); echo_inv = 1;
    send_req(2'd2, 5'd1, 1);
    host_if.req_ss = 2'd0;
    wait_done(1, 100, "t4_first");
    d1 = done_cyc;
    for (int i = 0; i < 10 && n_hs < 2; i++) step();
    host_if.req_valid = 0;
    wait_done(2, 100, "t4_second");
    repeat (3) step();
    chk("t4_nhs", 32'(n_hs), 2);
    chk("t4_hs2_at_done", 32'(hs_cyc[1] - d1), 0);
    chk("t4_ss_gap", 32'(fall_cyc[1] - rise_cyc[0]), 2);
    chk("t4_ss_val0", 32'(fall_val[0]), 32'hB);
    chk("t4_ss_val1", 32'(fall_val[1]), 32'hE);
    chk("t4_nstart", 32'(n_start), 2);

    // Reset during byte 2 of 3
    clear_stats(); setup_tx(3, 8'h20, 0);
    send_req(2'd1, 5'd3, 0);
    for (int i = 0; i < 200 && n_start < 2; i++) step();
    step();
    chk("t5_pre_ss", 32'(ss_n), 32'hD);
    reset = 1;
    #1;
    chk("t5_ss_n", 32'(ss_n), 32'hF);
    chk("t5_spi_start", 32'(spi_start), 0);
    chk("t5_tx_ready", 32'(host_if.tx_ready), 0);
    chk("t5_rx_valid", 32'(host_if.rx_valid), 0);
    chk("t5_xfer_done", 32'(host_if.xfer_done), 0);
    chk("t5_busy", 32'(host_if.busy), 0);
    core_cnt = 0; start_pending = 0; spi_ready = 1; spi_done_tick = 0;
    setup_tx(0, 8'h00, 0);
    @(posedge clk); #1 reset = 0;
    repeat (4) step();
    chk("t5_req_ready", 32'(host_if.req_ready), 1);
    chk("t5_ss_after", 32'(ss_n), 32'hF);
    chk("t5_nrx", 32'(n_rx), 1);
    chk("t5_ndone", 32'(n_done), 0);

`ifdef SPI_XFER_CTRL_TIMEOUT_EN
    // Core never completes the byte
    clear_stats(); setup_tx(2, 8'h30, 0); core_mute = 1;
    send_req(2'd0, 5'd2, 0);
    wait_done(1, 200, "t6_finish");
    repeat (3) step();
    chk("t6_nerr", 32'(n_err), 1);
    chk("t6_err_with_done", 32'(err_cyc - done_cyc), 0);
    chk("t6_err_lat", 32'(err_cyc - start_cyc), 21);
    chk("t6_nrx", 32'(n_rx), 0);
    chk("t6_ss_release", 32'(rise_cyc[0] - done_cyc), 0);
    chk("t6_nstart", 32'(n_start), 1);
    core_mute = 0; spi_ready = 1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
